// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the single-port data RAM; grant registered, 1-cycle min request-to-grant, read data returned 1 cycle after its grant.
// Requesters hold their beat until granted; a locked owner keeps the grant for at most MAX_HOLD beats while the other waits.
module dmem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [1:0]          lock,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [1:0]          gnt,
   output logic [1:0]          rvalid,
   output logic [DATA_W-1:0]   rdata,
   output logic                mem_wEn,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_dataIn,
   input  logic [DATA_W-1:0]   mem_dataOut
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

   // Encoding doubles as the grant vector.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic          last_owner_q, last_owner_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]    rvalid_q, rvalid_d;
   logic          owned;
   logic          owner;
   logic          eff_last;

   assign owned    = (state_q != IDLE);
   assign owner    = (state_q == OWN1);
   // The beat granted this cycle counts as the most recent owner.
   assign eff_last = owned ? owner : last_owner_q;

   always_comb begin
      state_d      = IDLE;
      hold_cnt_d   = '0;
      last_owner_d = eff_last;
      if (owned && req[owner] && lock[owner] && (hold_cnt_q < HOLD_TOP)) begin
         state_d    = state_q;
         hold_cnt_d = hold_cnt_q + 1'b1;
      end else if (req == 2'b11) begin
         state_d = eff_last ? OWN0 : OWN1;
      end else if (req != 2'b00) begin
         state_d = req[1] ? OWN1 : OWN0;
         if (owned && (req[1] == owner)) begin
            hold_cnt_d = (hold_cnt_q == HOLD_TOP) ? hold_cnt_q : hold_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      rvalid_d = gnt & ~we;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         hold_cnt_q   <= '0;
         rvalid_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         hold_cnt_q   <= hold_cnt_d;
         rvalid_q     <= rvalid_d;
      end
   end

   assign gnt        = state_q;
   assign rvalid     = rvalid_q;
   assign rdata      = mem_dataOut;
   // Writes are suppressed in a reset cycle even if a burst is mid-flight.
   assign mem_wEn    = (|(gnt & we)) & ~reset;
   assign mem_addr   = owner ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
   assign mem_dataIn = owner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: requester drivers, a RAM model, and a scoreboard of expected grants and read returns.
module tb_dmem_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   typedef struct packed {
      logic          we;
      logic          lock;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct packed {
      int unsigned   cyc;
      logic [1:0]    gnt;
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } gexp_t;

   typedef struct packed {
      int unsigned   cyc;
      logic [1:0]    rv;
      logic [DW-1:0] data;
   } rexp_t;

   logic          clock;
   logic          reset;
   logic [1:0]    req;
   logic [1:0]    we;
   logic [1:0]    lock;
   logic [2*AW-1:0] addr;
   logic [2*DW-1:0] wdata;
   logic [1:0]    gnt;
   logic [1:0]    rvalid;
   logic [DW-1:0] rdata;
   logic          mem_wEn;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dataIn;
   logic [DW-1:0] mem_dataOut;

   logic [DW-1:0] ram [0:4095];
   int unsigned   cyc = 0;
   int            ncmp;
   int            nerr;
   logic          mon_en;

   beat_t bq0[$];
   beat_t bq1[$];
   gexp_t gq[$];
   rexp_t rq[$];

   logic [AW-1:0] la  [8]  = '{12'h100, 12'h101, 12'h102, 12'h200, 12'h201, 12'h202, 12'h100, 12'h200};
   logic [DW-1:0] ld  [8]  = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hB0000000,
                               32'hB0000001, 32'hB0000002, 32'hA0000000, 32'hB0000000};
   logic [AW-1:0] la2 [5]  = '{12'h200, 12'h201, 12'h202, 12'h020, 12'h010};
   logic [DW-1:0] ld2 [5]  = '{32'hB0000000, 32'hB0000001, 32'hB0000002, 32'h11112222, 32'hDEADBEEF};

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .we          (we),
      .lock        (lock),
      .addr        (addr),
      .wdata       (wdata),
      .gnt         (gnt),
      .rvalid      (rvalid),
      .rdata       (rdata),
      .mem_wEn     (mem_wEn),
      .mem_addr    (mem_addr),
      .mem_dataIn  (mem_dataIn),
      .mem_dataOut (mem_dataOut)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous-read RAM model.
   always @(posedge clock) begin
      if (mem_wEn) ram[mem_addr] <= mem_dataIn;
      mem_dataOut <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic beat(input int i, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
      beat_t b;
      b.we = w; b.lock = l; b.addr = a; b.data = d;
      if (i == 0) bq0.push_back(b);
      else        bq1.push_back(b);
   endtask

   task automatic exp_g(input int unsigned c, input logic [1:0] g, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      gexp_t e;
      e.cyc = c; e.gnt = g; e.wen = w; e.addr = a; e.data = d;
      gq.push_back(e);
   endtask

   task automatic exp_r(input int unsigned c, input logic [1:0] rv, input logic [DW-1:0] d);
      rexp_t e;
      e.cyc = c; e.rv = rv; e.data = d;
      rq.push_back(e);
   endtask

   // Present the head beat; during a granted cycle req means another beat follows.
   task automatic drive();
      if (bq0.size() > 0) begin
         we[0] = bq0[0].we; lock[0] = bq0[0].lock;
         addr[AW-1:0] = bq0[0].addr; wdata[DW-1:0] = bq0[0].data;
         req[0] = gnt[0] ? (bq0.size() > 1) : 1'b1;
      end else begin
         req[0] = 1'b0; we[0] = 1'b0; lock[0] = 1'b0;
      end
      if (bq1.size() > 0) begin
         we[1] = bq1[0].we; lock[1] = bq1[0].lock;
         addr[2*AW-1:AW] = bq1[0].addr; wdata[2*DW-1:DW] = bq1[0].data;
         req[1] = gnt[1] ? (bq1.size() > 1) : 1'b1;
      end else begin
         req[1] = 1'b0; we[1] = 1'b0; lock[1] = 1'b0;
      end
   endtask

   task automatic step();
      logic [1:0] gp;
      gp = gnt;
      @(posedge clock); #1;
      if (gp[0] && bq0.size() > 0) void'(bq0.pop_front());
      if (gp[1] && bq1.size() > 0) void'(bq1.pop_front());
      drive();
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while ((bq0.size() != 0 || bq1.size() != 0 || gnt != 2'b00) && n < budget) begin
         step();
         n++;
      end
      chk("drain_within_budget", 64'(n < budget), 64'd1);
   endtask

   task automatic reset_checks();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_wEn", 64'(mem_wEn), 64'd0);
   endtask

   // Scoreboard monitor.
   initial begin
      gexp_t g;
      rexp_t r;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (gnt != 2'b00) begin
               if (gq.size() == 0) chk("unexpected_gnt", 64'(gnt), 64'd0);
               else begin
                  g = gq.pop_front();
                  chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
                  chk("gnt_value", 64'(gnt), 64'(g.gnt));
                  chk("mem_wEn", 64'(mem_wEn), 64'(g.wen));
                  chk("mem_addr", 64'(mem_addr), 64'(g.addr));
                  if (g.wen) chk("mem_dataIn", 64'(mem_dataIn), 64'(g.data));
               end
            end else begin
               chk("idle_wEn", 64'(mem_wEn), 64'd0);
            end
            if (rvalid != 2'b00) begin
               if (rq.size() == 0) chk("unexpected_rvalid", 64'(rvalid), 64'd0);
               else begin
                  r = rq.pop_front();
                  chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
                  chk("rvalid_value", 64'(rvalid), 64'(r.rv));
                  chk("rdata", 64'(rdata), 64'(r.data));
               end
            end
         end
      end
   end

   initial begin
      int unsigned c;
      ncmp = 0; nerr = 0; mon_en = 1'b0;
      reset = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
      for (int i = 0; i < 4096; i++) ram[i] = '0;

      // Reset held with both requesters pending, then unlocked contention.
      @(posedge clock); #1;
      mon_en = 1'b1;
      reset_checks();
      for (int k = 0; k < 3; k++) begin
         beat(0, 1'b1, 1'b0, AW'(12'h100 + k), 32'hA0000000 + 32'(k));
         beat(1, 1'b1, 1'b0, AW'(12'h200 + k), 32'hB0000000 + 32'(k));
      end
      drive();
      repeat (2) begin
         @(posedge clock); #1;
         reset_checks();
      end
      reset = 1'b0;
      c = cyc;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) exp_g(c + 1 + k, 2'b01, 1'b1, AW'(12'h100 + k / 2), 32'hA0000000 + 32'(k / 2));
         else            exp_g(c + 1 + k, 2'b10, 1'b1, AW'(12'h200 + k / 2), 32'hB0000000 + 32'(k / 2));
      end
      run_until_idle(40);

      // Locked 8-beat read burst on 0 against a single write from 1.
      c = cyc;
      for (int k = 0; k < 8; k++) beat(0, 1'b0, 1'b1, la[k], '0);
      beat(1, 1'b1, 1'b0, 12'h020, 32'h11112222);
      drive();
      for (int k = 0; k < 8; k++) begin
         if (k == 4) exp_g(c + 5, 2'b10, 1'b1, 12'h020, 32'h11112222);
         exp_g(c + 1 + k + ((k >= 4) ? 1 : 0), 2'b01, 1'b0, la[k], '0);
         exp_r(c + 2 + k + ((k >= 4) ? 1 : 0), 2'b01, ld[k]);
      end
      run_until_idle(40);

      // Single write then read-back.
      c = cyc;
      beat(0, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF);
      beat(0, 1'b0, 1'b0, 12'h010, '0);
      drive();
      exp_g(c + 1, 2'b01, 1'b1, 12'h010, 32'hDEADBEEF);
      exp_g(c + 2, 2'b01, 1'b0, 12'h010, '0);
      exp_r(c + 3, 2'b01, 32'hDEADBEEF);
      run_until_idle(20);

      // Lone locked requester 1 keeps the grant for all 10 reads.
      c = cyc;
      for (int k = 0; k < 10; k++) begin
         beat(1, 1'b0, 1'b1, la2[k % 5], '0);
         exp_g(c + 1 + k, 2'b10, 1'b0, la2[k % 5], '0);
         exp_r(c + 2 + k, 2'b10, ld2[k % 5]);
      end
      drive();
      run_until_idle(40);

      // Reset lands on the second beat of a write burst.
      c = cyc;
      beat(1, 1'b1, 1'b1, 12'h300, 32'hC0C0C0C0);
      beat(1, 1'b1, 1'b1, 12'h301, 32'hC1C1C1C1);
      beat(1, 1'b1, 1'b1, 12'h302, 32'hC2C2C2C2);
      drive();
      exp_g(c + 1, 2'b10, 1'b1, 12'h300, 32'hC0C0C0C0);
      exp_g(c + 2, 2'b10, 1'b0, 12'h301, 32'hC1C1C1C1);
      step();
      step();
      reset = 1'b1;
      @(posedge clock); #1;
      chk("post_rst_gnt", 64'(gnt), 64'd0);
      chk("post_rst_rvalid", 64'(rvalid), 64'd0);
      bq0.delete();
      bq1.delete();
      reset = 1'b0;
      c = cyc;
      beat(0, 1'b0, 1'b0, 12'h300, '0);
      beat(0, 1'b0, 1'b0, 12'h301, '0);
      beat(0, 1'b0, 1'b0, 12'h302, '0);
      drive();
      exp_g(c + 1, 2'b01, 1'b0, 12'h300, '0);
      exp_g(c + 2, 2'b01, 1'b0, 12'h301, '0);
      exp_g(c + 3, 2'b01, 1'b0, 12'h302, '0);
      exp_r(c + 2, 2'b01, 32'hC0C0C0C0);
      exp_r(c + 3, 2'b01, 32'h00000000);
      exp_r(c + 4, 2'b01, 32'h00000000);
      run_until_idle(20);

      repeat (3) @(posedge clock);
      #1;
      chk("grants_outstanding", 64'(gq.size()), 64'd0);
      chk("reads_outstanding", 64'(rq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
